// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and its surroundings.
// The master side is the sequencer; the slave side is the PLL wrapper / system.
interface pll_reset_sequencer_if;
  logic       pll_locked;
  logic       soft_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [1:0] retry_count;
  logic [7:0] lost_count;
  logic [2:0] state_dbg;

  modport master (
    input  pll_locked, soft_req,
    output pll_rst, sys_rst, ready, fault, retry_count, lost_count, state_dbg
  );

  modport slave (
    output pll_locked, soft_req,
    input  pll_rst, sys_rst, ready, fault, retry_count, lost_count, state_dbg
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Pulses the PLL reset, qualifies lock for a stable interval before releasing the
// system reset, retries on lock timeout and latches a fault after repeated failures.
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 17
) (
  input  logic                  refclk,
  input  logic                  rst,
  pll_reset_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       retry_reg, retry_next;
  logic [7:0]       lost_reg, lost_next;
  logic             pll_rst_reg, pll_rst_next;
  logic             sys_rst_reg, sys_rst_next;
  logic             ready_reg, ready_next;
  logic             fault_reg, fault_next;
  logic [1:0]       sync_reg;
  logic             locked_s;

  // Two-stage synchronizer for the asynchronous lock indication.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
          sync_reg[gi] <= 1'b0;
        end else if (gi == 0) begin
          sync_reg[gi] <= bus.pll_locked;
        end else begin
          sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign locked_s = sync_reg[1];

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_reg   <= RESET_PLL;
      cnt_reg     <= '0;
      retry_reg   <= '0;
      lost_reg    <= '0;
      pll_rst_reg <= 1'b1;
      sys_rst_reg <= 1'b1;
      ready_reg   <= 1'b0;
      fault_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      retry_reg   <= retry_next;
      lost_reg    <= lost_next;
      pll_rst_reg <= pll_rst_next;
      sys_rst_reg <= sys_rst_next;
      ready_reg   <= ready_next;
      fault_reg   <= fault_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    retry_next = retry_reg;
    lost_next  = lost_reg;

    if (bus.soft_req) begin
      state_next = RESET_PLL;
      cnt_next   = '0;
      retry_next = '0;
    end else begin
      case (state_reg)
        RESET_PLL: begin
          if (cnt_reg == RST_LAST) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_next = STABLE;
            cnt_next   = '0;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            cnt_next = '0;
            if (retry_reg == RETRY_MAX) begin
              state_next = FAULT;
            end else begin
              state_next = RESET_PLL;
              retry_next = retry_reg + 2'd1;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else if (cnt_reg == STABLE_LAST) begin
            state_next = RUN;
            cnt_next   = '0;
            retry_next = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
            if (lost_reg != 8'hFF) begin
              lost_next = lost_reg + 8'd1;
            end
          end
        end
        FAULT: begin
          state_next = FAULT;
        end
        default: begin
          state_next = RESET_PLL;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move on the same edge as the state.
  always_comb begin
    pll_rst_next = (state_next == RESET_PLL) || (state_next == FAULT);
    sys_rst_next = (state_next != RUN);
    ready_next   = (state_next == RUN);
    fault_next   = (state_next == FAULT);
  end

  assign bus.pll_rst     = pll_rst_reg;
  assign bus.sys_rst     = sys_rst_reg;
  assign bus.ready       = ready_reg;
  assign bus.fault       = fault_reg;
  assign bus.retry_count = retry_reg;
  assign bus.lost_count  = lost_reg;
  assign bus.state_dbg   = state_reg;

endmodule
